key_debouncer: RTL and testbench

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_debouncer.sv | 141 ++++++++++++++
 tb/tb_key_debouncer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Multi-channel pushbutton debouncer: 2-flop synchronizer, per-key debounce FSM, press/release strobes.
// Optional auto-repeat of press_pulse while a key is held, enabled by defining KEY_REPEAT_EN.
module key_debouncer #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] key_n_in,
    output logic [N_KEYS-1:0] keys_export,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sample;
    state_t            state [N_KEYS];
    logic [CNT_W-1:0]  cnt   [N_KEYS];

`ifdef KEY_REPEAT_EN
    localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W    = $clog2(RPT_SPAN + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]  rpt_cnt [N_KEYS];
    logic [N_KEYS-1:0] rpt_armed;
`endif

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debouncer: illegal parameter value");
    end

    // Two-flop synchronizer; released level (1) is the idle value
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_meta <= '1;
            sample    <= '1;
        end else begin
            sync_meta <= key_n_in;
            sample    <= sync_meta;
        end
    end

    // Per-key debounce FSMs with registered level and strobe outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            keys_export   <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                state[k] <= UP;
                cnt[k]   <= '0;
`ifdef KEY_REPEAT_EN
                rpt_cnt[k]   <= '0;
                rpt_armed[k] <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                press_pulse[k]   <= 1'b0;
                release_pulse[k] <= 1'b0;
`ifdef KEY_REPEAT_EN
                // Repeat timing restarts from zero on every entry into DOWN
                if (state[k] != DOWN) begin
                    rpt_cnt[k]   <= '0;
                    rpt_armed[k] <= 1'b0;
                end
`endif
                case (state[k])
                    UP: begin
                        cnt[k] <= '0;
                        if (!sample[k]) begin
                            state[k] <= WAIT_DOWN;
                        end
                    end
                    WAIT_DOWN: begin
                        if (sample[k]) begin
                            state[k] <= UP;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_LAST) begin
                            state[k]       <= DOWN;
                            cnt[k]         <= '0;
                            keys_export[k] <= 1'b0;
                            press_pulse[k] <= 1'b1;
                        end else if (cnt[k] != CNT_MAX) begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    DOWN: begin
                        cnt[k] <= '0;
                        if (sample[k]) begin
                            state[k] <= WAIT_UP;
                        end
`ifdef KEY_REPEAT_EN
                        else if (rpt_cnt[k] == (rpt_armed[k] ? RPT_NEXT : RPT_FIRST)) begin
                            press_pulse[k] <= 1'b1;
                            rpt_cnt[k]     <= '0;
                            rpt_armed[k]   <= 1'b1;
                        end else begin
                            rpt_cnt[k] <= rpt_cnt[k] + RPT_W'(1);
                        end
`endif
                    end
                    WAIT_UP: begin
                        if (!sample[k]) begin
                            state[k] <= DOWN;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_LAST) begin
                            state[k]         <= UP;
                            cnt[k]           <= '0;
                            keys_export[k]   <= 1'b1;
                            release_pulse[k] <= 1'b1;
                        end else if (cnt[k] != CNT_MAX) begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[k]       <= UP;
                        cnt[k]         <= '0;
                        keys_export[k] <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus randomized bouncing keys,
// all checked against a run-length reference model of the debounce rules.
module tb_key_debouncer;

    localparam int N  = 3;
    localparam int DC = 4;
`ifdef KEY_REPEAT_EN
    localparam int RD = 8;
    localparam int RP = 4;
`endif

    logic         clk = 1'b0;
    logic         reset_reset;
    logic [N-1:0] key_n_in;
    logic [N-1:0] keys_export;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    key_debouncer #(
        .N_KEYS         (N),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (reset_reset),
        .key_n_in     (key_n_in),
        .keys_export  (keys_export),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    // Reference model: a level is accepted after DC+1 consecutive differing samples,
    // where the sample seen at an edge is the pin value from two edges earlier.
    logic [N-1:0] dly1 = '1, dly2 = '1, seen;
    logic [N-1:0] stable   = '1;
    logic [N-1:0] exp_keys = '1, exp_press = '0, exp_rel = '0;
    int run  [N];
    int held [N];

    always @(posedge clk) begin
        if (reset_reset) begin
            dly1 = '1; dly2 = '1; stable = '1;
            exp_keys = '1; exp_press = '0; exp_rel = '0;
            for (int k = 0; k < N; k++) begin
                run[k] = 0; held[k] = 0;
            end
        end else begin
            seen = dly2; dly2 = dly1; dly1 = key_n_in;
            exp_press = '0; exp_rel = '0;
            for (int k = 0; k < N; k++) begin
                if (seen[k] != stable[k]) begin
                    run[k]++;
                    held[k] = 0;
                    if (run[k] == DC + 1) begin
                        stable[k] = seen[k];
                        run[k] = 0;
                        if (seen[k] == 1'b0) exp_press[k] = 1'b1;
                        else exp_rel[k] = 1'b1;
                    end
                end else if (run[k] > 0) begin
                    run[k] = 0;
                    held[k] = 0;
                end else if (stable[k] == 1'b0) begin
`ifdef KEY_REPEAT_EN
                    held[k]++;
                    if (held[k] == RD || (held[k] > RD && (held[k] - RD) % RP == 0))
                        exp_press[k] = 1'b1;
`endif
                end
            end
            exp_keys = stable;
        end
    end

    task automatic test_reset();
        int first;
        first = -1;
        key_n_in = 3'b000;
        reset_reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if (keys_export !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got keys/press/rel %b/%b/%b, expected 111/000/000",
                         i, keys_export, press_pulse, release_pulse);
            end
        end
        reset_reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if (keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel) begin
                miscompares++;
                $display("FAIL reset_release cycle %0d: got %b/%b/%b expected %b/%b/%b",
                         i, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
            end
            if (first < 0 && press_pulse[0] === 1'b1) first = i;
        end
        vectors++;
        if (first != 7) begin
            miscompares++;
            $display("FAIL reset_first_press: got cycle %0d, expected cycle 7", first);
        end
    endtask

    task automatic test_release_all();
        key_n_in = 3'b111;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if (keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel) begin
                miscompares++;
                $display("FAIL release_all cycle %0d: got %b/%b/%b expected %b/%b/%b",
                         i, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
            end
        end
        vectors++;
        if (keys_export !== 3'b111) begin
            miscompares++;
            $display("FAIL release_all_level: got %b, expected 111", keys_export);
        end
    endtask

    task automatic test_press_release();
        for (int phase = 0; phase < 2; phase++) begin
            int hits, at;
            hits = 0; at = -1;
            key_n_in[0] = (phase == 1);
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                vectors++;
                if (keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel) begin
                    miscompares++;
                    $display("FAIL press_release phase %0d cycle %0d: got %b/%b/%b expected %b/%b/%b",
                             phase, i, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
                end
                if ((phase == 0 ? press_pulse[0] : release_pulse[0]) === 1'b1) begin
                    hits++;
                    at = i;
                end
            end
            vectors++;
            if (hits != 1 || at != 7 || keys_export[0] !== (phase == 1)) begin
                miscompares++;
                $display("FAIL press_release_timing phase %0d: got %0d pulses at cycle %0d level %b, expected 1 at cycle 7 level %0d",
                         phase, hits, at, keys_export[0], phase);
            end
        end
    endtask

    task automatic test_bounce();
        key_n_in[1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if (keys_export !== 3'b111 || press_pulse !== 3'b000 || release_pulse !== 3'b000) begin
                miscompares++;
                $display("FAIL bounce cycle %0d: got %b/%b/%b, expected 111/000/000",
                         i, keys_export, press_pulse, release_pulse);
            end
            if (i == 3) key_n_in[1] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        for (int phase = 0; phase < 2; phase++) begin
            key_n_in = (phase == 0) ? 3'b000 : 3'b111;
            for (int i = 1; i <= 10; i++) begin
                logic [N-1:0] want;
                @(negedge clk);
                want = (i == 7) ? 3'b111 : 3'b000;
                vectors++;
                if ((phase == 0 ? press_pulse : release_pulse) !== want ||
                    (phase == 0 ? release_pulse : press_pulse) !== 3'b000) begin
                    miscompares++;
                    $display("FAIL simultaneous phase %0d cycle %0d: got press %b rel %b, expected strobe %b",
                             phase, i, press_pulse, release_pulse, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        key_n_in[0] = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vectors++;
            if (press_pulse[0] !== (i == 13) || keys_export[0] !== (i < 13) ||
                keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel) begin
                miscompares++;
                $display("FAIL reset_mid_wait cycle %0d: got %b/%b/%b model %b/%b/%b, key0 press only at 13",
                         i, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
            end
            if (i == 4) reset_reset = 1'b1;
            if (i == 6) reset_reset = 1'b0;
        end
    endtask

    task automatic test_repeat();
        int q[$];
        int want_n;
        key_n_in[0] = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            vectors++;
            if (keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel) begin
                miscompares++;
                $display("FAIL repeat cycle %0d: got %b/%b/%b expected %b/%b/%b",
                         i, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
            end
            if (press_pulse[0] === 1'b1) q.push_back(i);
            if (i == 30) key_n_in[0] = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        want_n = 6;
`else
        want_n = 1;
`endif
        vectors++;
        if (q.size() != want_n || q[0] != 7) begin
            miscompares++;
            $display("FAIL repeat_count: got %0d pulses first at %0d, expected %0d first at 7",
                     q.size(), (q.size() > 0) ? q[0] : -1, want_n);
        end
`ifdef KEY_REPEAT_EN
        vectors++;
        if (q.size() < 3 || q[1] != 15 || q[2] != 19) begin
            miscompares++;
            $display("FAIL repeat_spacing: got %0d pulses, expected second at 15 and third at 19", q.size());
        end
`endif
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 40; seg++) begin
            int bouncy;
            bouncy = $urandom_range(0, 1);
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                vectors++;
                if (keys_export !== exp_keys || press_pulse !== exp_press || release_pulse !== exp_rel ||
                    (press_pulse & release_pulse) !== 3'b000) begin
                    miscompares++;
                    $display("FAIL random seg %0d cycle %0d: got %b/%b/%b expected %b/%b/%b",
                             seg, c, keys_export, press_pulse, release_pulse, exp_keys, exp_press, exp_rel);
                end
                for (int b = 0; b < N; b++) begin
                    if (bouncy != 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0))
                        key_n_in[b] = ~key_n_in[b];
                end
            end
        end
    endtask

    initial begin
        reset_reset = 1'b1;
        key_n_in    = 3'b000;
        test_reset();
        test_release_all();
        test_press_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_wait();
        test_release_all();
        test_repeat();
        test_release_all();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
